// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Word and word-address widths used by the cache/memory side.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_ADDR_W = 30;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-side request/response and RAM-side port bundle
// for the memory responder.
interface mem_responder_if;
  import cpu_types_pkg::*;

  logic       iREN;
  word_t      iaddr;
  logic       iwait;
  word_t      iload;

  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;

  logic       ram_ren;
  logic       ram_wen;
  word_addr_t ram_addr;
  word_t      ram_wdata;
  word_t      ram_rdata;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ram_rdata,
    output iwait, iload,
    output dwait, dload,
    output ram_ren, ram_wen,
    output ram_addr, ram_wdata
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ram_rdata,
    input  iwait, iload,
    input  dwait, dload,
    input  ram_ren, ram_wen,
    input  ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_responder.sv
// Memory responder: arbitrates I/D word requests, inserts a fixed
// latency, drives a single-port sync RAM and pulses completion.
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input logic            CLK,
  input logic            RST,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LAT) - 4'd1;
  localparam bit         LAT_ZERO = (LAT == 0);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dmst_q, dmst_d;
  logic       wr_q, wr_d;
  word_addr_t addr_q, addr_d;
  word_t      wdata_q, wdata_d;
  logic       ren_q, ren_d;
  logic       wen_q, wen_d;
  logic       iwait_q, iwait_d;
  logic       dwait_q, dwait_d;
  word_t      iload_q, iload_d;
  word_t      dload_q, dload_d;

  logic       req_g;
  logic       any_req;
  logic       unused_lsb;

  assign unused_lsb = ^{bus.iaddr[1:0], bus.daddr[1:0]};
  assign any_req    = bus.dWEN | bus.dREN | bus.iREN;
  assign req_g      = dmst_q ? (bus.dREN | bus.dWEN) : bus.iREN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dmst_d  = dmst_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    iwait_d = 1'b1;
    dwait_d = 1'b1;
    iload_d = iload_q;
    dload_d = dload_q;
    unique case (state_q)
      S_IDLE: begin
        // data beats instruction; a write beats a read
        if (bus.dWEN || bus.dREN) begin
          dmst_d = 1'b1;
          wr_d   = bus.dWEN;
          addr_d = bus.daddr[31:2];
        end else if (bus.iREN) begin
          dmst_d = 1'b0;
          wr_d   = 1'b0;
          addr_d = bus.iaddr[31:2];
        end
        if (any_req) begin
          wdata_d = bus.dstore;
          cnt_d   = CNT_INIT;
          if (LAT_ZERO) begin
            state_d = S_ACCESS;
            ren_d   = !wr_d;
            wen_d   = wr_d;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req_g) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
          ren_d   = !wr_q;
          wen_d   = wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d = S_DONE;
          dwait_d = 1'b0;
          dload_d = '0;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_DONE;
        if (dmst_q) begin
          dwait_d = 1'b0;
          dload_d = bus.ram_rdata;
        end else begin
          iwait_d = 1'b0;
          iload_d = bus.ram_rdata;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dmst_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iwait_q <= 1'b1;
      dwait_q <= 1'b1;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dmst_q  <= dmst_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      iwait_q <= iwait_d;
      dwait_q <= dwait_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  assign bus.iwait     = iwait_q;
  assign bus.iload     = iload_q;
  assign bus.dwait     = dwait_q;
  assign bus.dload     = dload_q;
  assign bus.ram_ren   = ren_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LAT 2, 0, 4), each with
// its own RAM model, driven from a vector table plus corner sequences.
module tb_mem_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [2:0] iren, dren, dwen;
  word_t      iaddr [3];
  word_t      daddr [3];
  word_t      dstore [3];
  logic [2:0] iw_a, dw_a, ren_a, wen_a;
  word_t      il_a [3];
  word_t      dl_a [3];
  word_t      wd_a [3];
  logic [29:0] ra_a [3];

  logic       pre_we;
  int         pre_sel;
  logic [7:0] pre_a;
  word_t      pre_d;

  int n_chk = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 0 : 4);
    mem_responder_if u_if ();
    word_t mem [256];

    assign u_if.iREN   = iren[g];
    assign u_if.iaddr  = iaddr[g];
    assign u_if.dREN   = dren[g];
    assign u_if.dWEN   = dwen[g];
    assign u_if.daddr  = daddr[g];
    assign u_if.dstore = dstore[g];
    assign iw_a[g]     = u_if.iwait;
    assign dw_a[g]     = u_if.dwait;
    assign ren_a[g]    = u_if.ram_ren;
    assign wen_a[g]    = u_if.ram_wen;
    assign il_a[g]     = u_if.iload;
    assign dl_a[g]     = u_if.dload;
    assign wd_a[g]     = u_if.ram_wdata;
    assign ra_a[g]     = u_if.ram_addr;

    always @(posedge CLK) begin
      if (pre_we && pre_sel == g)
        mem[pre_a] <= pre_d;
      else if (u_if.ram_wen)
        mem[u_if.ram_addr[7:0]] <= u_if.ram_wdata;
      if (u_if.ram_ren)
        u_if.ram_rdata <= mem[u_if.ram_addr[7:0]];
    end

    mem_responder #(.LAT(L)) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (u_if.slave)
    );
  end

  typedef struct {
    int          k;
    logic        ir, dr, dw;
    word_t       ia, da, ds;
    int          e_ren, e_wen, e_dw, e_iw;
    word_t       e_dl, e_il;
    int          e_nren, e_nwen;
    logic [29:0] e_addr;
  } vec_t;

  typedef struct {
    int          c_ren, c_wen, c_dw, c_iw;
    int          n_ren, n_wen, n_dwl, n_iwl;
    word_t       dl, il;
    logic [29:0] a0;
  } res_t;

  vec_t tv [8];
  res_t r;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int k, input logic [7:0] a, input word_t d);
    pre_sel = k;
    pre_a   = a;
    pre_d   = d;
    pre_we  = 1'b1;
    @(posedge CLK); #1;
    pre_we  = 1'b0;
  endtask

  // Issue at cycle 0 (now), hold until completion, then observe one
  // extra cycle; cycle c is the window #1 after the c-th rising edge.
  task automatic run(input int k, input logic ir, dr, dw,
                     input word_t ia, da, ds, output res_t o);
    int  extra;
    bit  a_set;
    o = '{-1, -1, -1, -1, 0, 0, 0, 0, 32'h0, 32'h0, 30'h0};
    extra = 0;
    a_set = 1'b0;
    iren[k] = ir; dren[k] = dr; dwen[k] = dw;
    iaddr[k] = ia; daddr[k] = da; dstore[k] = ds;
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK); #1;
      if (ren_a[k]) begin
        o.n_ren++;
        if (o.c_ren < 0) o.c_ren = c;
      end
      if (wen_a[k]) begin
        o.n_wen++;
        if (o.c_wen < 0) o.c_wen = c;
      end
      if ((ren_a[k] || wen_a[k]) && !a_set) begin
        a_set = 1'b1;
        o.a0 = ra_a[k];
      end
      if (!dw_a[k]) begin
        o.n_dwl++;
        if (o.c_dw < 0) begin
          o.c_dw = c;
          o.dl = dl_a[k];
        end
        dren[k] = 1'b0;
        dwen[k] = 1'b0;
      end
      if (!iw_a[k]) begin
        o.n_iwl++;
        if (o.c_iw < 0) begin
          o.c_iw = c;
          o.il = il_a[k];
        end
        iren[k] = 1'b0;
      end
      if ((o.c_dw >= 0 || !(dr || dw)) && (o.c_iw >= 0 || !ir)) begin
        extra++;
        if (extra == 2) break;
      end
    end
    iren[k] = 1'b0; dren[k] = 1'b0; dwen[k] = 1'b0;
  endtask

  task automatic chk_rst(input int k);
    string p;
    p = $sformatf("rst%0d", k);
    chk({p, " waits"}, {30'h0, iw_a[k], dw_a[k]}, 32'h3);
    chk({p, " strobes"}, {30'h0, ren_a[k], wen_a[k]}, 32'h0);
    chk({p, " ram_addr"}, {2'b00, ra_a[k]}, 32'h0);
    chk({p, " ram_wdata"}, wd_a[k], 32'h0);
    chk({p, " iload"}, il_a[k], 32'h0);
    chk({p, " dload"}, dl_a[k], 32'h0);
  endtask

  int nstb, ndwl;

  initial begin
    RST = 1'b1;
    pre_we = 1'b0; pre_sel = 0; pre_a = '0; pre_d = '0;
    iren = '0; dren = '0; dwen = '0;
    for (int k = 0; k < 3; k++) begin
      iaddr[k] = '0; daddr[k] = '0; dstore[k] = '0;
    end
    @(posedge CLK); #1;
    preload(0, 8'h10, 32'hCAFEF00D);
    preload(0, 8'h30, 32'hA5A50001);
    preload(0, 8'h14, 32'h5555AAAA);
    preload(2, 8'h02, 32'h0BADC0DE);
    preload(2, 8'h10, 32'h00000077);
    for (int k = 0; k < 3; k++) chk_rst(k);
    RST = 1'b0;
    @(posedge CLK); #1;

    // k ir dr dw ia da ds ren wen dw iw dl il nren nwen addr
    tv[0] = '{0, 0, 1, 0, 0, 32'h40, 0, 3, -1, 5, -1,
              32'hCAFEF00D, 0, 1, 0, 30'h10};
    tv[1] = '{1, 0, 0, 1, 0, 32'h80, 32'h12345678, -1, 1, 2, -1,
              0, 0, 0, 1, 30'h20};
    tv[2] = '{1, 0, 1, 0, 0, 32'h80, 0, 1, -1, 3, -1,
              32'h12345678, 0, 1, 0, 30'h20};
    tv[3] = '{0, 1, 1, 0, 32'hC0, 32'h40, 0, 3, -1, 5, 11,
              32'hCAFEF00D, 32'hA5A50001, 2, 0, 30'h10};
    tv[4] = '{0, 0, 1, 1, 0, 32'h44, 32'hDEADBEEF, -1, 3, 4, -1,
              0, 0, 0, 1, 30'h11};
    tv[5] = '{0, 0, 1, 0, 0, 32'h44, 0, 3, -1, 5, -1,
              32'hDEADBEEF, 0, 1, 0, 30'h11};
    tv[6] = '{2, 1, 0, 0, 32'h08, 0, 0, 5, -1, -1, 7,
              0, 32'h0BADC0DE, 1, 0, 30'h02};
    tv[7] = '{0, 0, 0, 1, 0, 32'h4B, 32'h7, -1, 3, 4, -1,
              0, 0, 0, 1, 30'h12};

    for (int v = 0; v < 8; v++) begin
      run(tv[v].k, tv[v].ir, tv[v].dr, tv[v].dw,
          tv[v].ia, tv[v].da, tv[v].ds, r);
      chk($sformatf("v%0d ren_cyc", v), r.c_ren, tv[v].e_ren);
      chk($sformatf("v%0d wen_cyc", v), r.c_wen, tv[v].e_wen);
      chk($sformatf("v%0d dwait_cyc", v), r.c_dw, tv[v].e_dw);
      chk($sformatf("v%0d iwait_cyc", v), r.c_iw, tv[v].e_iw);
      if (tv[v].e_dw >= 0)
        chk($sformatf("v%0d dload", v), r.dl, tv[v].e_dl);
      if (tv[v].e_iw >= 0)
        chk($sformatf("v%0d iload", v), r.il, tv[v].e_il);
      chk($sformatf("v%0d n_ren", v), r.n_ren, tv[v].e_nren);
      chk($sformatf("v%0d n_wen", v), r.n_wen, tv[v].e_nwen);
      chk($sformatf("v%0d dwait_len", v), r.n_dwl,
          (tv[v].e_dw >= 0) ? 1 : 0);
      chk($sformatf("v%0d iwait_len", v), r.n_iwl,
          (tv[v].e_iw >= 0) ? 1 : 0);
      chk($sformatf("v%0d ram_addr", v), {2'b00, r.a0},
          {2'b00, tv[v].e_addr});
    end

    // abort: LAT=4 read dropped in cycle 2
    nstb = 0; ndwl = 0;
    dren[2] = 1'b1; daddr[2] = 32'h40;
    repeat (2) begin
      @(posedge CLK); #1;
      nstb += int'(ren_a[2] | wen_a[2]);
      ndwl += int'(!dw_a[2]);
    end
    dren[2] = 1'b0;
    @(posedge CLK); #1;
    nstb += int'(ren_a[2] | wen_a[2]);
    ndwl += int'(!dw_a[2]);
    chk("abort strobes", nstb, 0);
    chk("abort dwait", ndwl, 0);
    run(2, 0, 1, 0, 0, 32'h40, 0, r);
    chk("post_abort ren_cyc", r.c_ren, 5);
    chk("post_abort dwait_cyc", r.c_dw, 7);
    chk("post_abort dload", r.dl, 32'h77);

    // reset while a write is in WAIT
    nstb = 0;
    dwen[0] = 1'b1; daddr[0] = 32'h50; dstore[0] = 32'h99;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk_rst(0);
    repeat (3) begin
      @(posedge CLK); #1;
      nstb += int'(ren_a[0] | wen_a[0]);
    end
    RST = 1'b0;
    dwen[0] = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      nstb += int'(ren_a[0] | wen_a[0]);
    end
    chk("reset strobes", nstb, 0);
    run(0, 0, 1, 0, 0, 32'h50, 0, r);
    chk("post_rst ren_cyc", r.c_ren, 3);
    chk("post_rst dwait_cyc", r.c_dw, 5);
    chk("post_rst dload", r.dl, 32'h5555AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the cache/memory request protocol. It accepts word requests from the instruction cache (read-only) and the data cache (read/write), arbitrates between them, models a fixed main-memory latency, and drives a single-port synchronous RAM. Each transaction is a single word; a cache block fill is built from consecutive requests. It holds the cache side in wait until each access completes, then signals completion for exactly one cycle.

## Interface
- LAT, 2: wait cycles inserted before each RAM access (0..15).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address (bits [1:0] ignored).
- iwait  out  1  low for one cycle when the instruction read completes.
- iload  out  32  instruction read data; valid while iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data word address (bits [1:0] ignored).
- dstore  in  32  data write value.
- dwait  out  1  low for one cycle when the data access completes.
- dload  out  32  data read data; valid while dwait is low.
- ram_ren  out  1  RAM read strobe; data returns on ram_rdata the next cycle.
- ram_wen  out  1  RAM write strobe; write commits at the edge.
- ram_addr  out  30  RAM word address = latched addr[31:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.

## Operation
- States: IDLE, WAIT, ACCESS, CAPTURE, DONE.
- IDLE: arbitration uses fixed priority. Data beats instruction. dWEN beats dREN; if both are high, the access is a write. A winning request latches the master, op, address and dstore. Next state is WAIT, or ACCESS if LAT=0. The counter loads LAT-1.
- WAIT: the counter decrements. At 0 the next state is ACCESS.
- ACCESS: assert ram_ren or ram_wen for one cycle using the latched address and data. A write goes to DONE. A read goes to CAPTURE.
- CAPTURE: register ram_rdata into the load register, then go to DONE.
- DONE: drive the granted master's wait low. Its load output carries the captured word; on a write it carries 0. Next state is IDLE.
- Wait outputs are 1 in every other state and for the non-granted master.
- Abort: if the granted master's request drops in WAIT, the block returns to IDLE with no RAM access. A drop after ACCESS does not cancel the access: a write still commits, DONE is still entered, and completion is ignored by the master.
- Latched fields never change mid-transaction, even if the master changes its address.
- The counter is 4 bits wide.
- Reset values: state IDLE; counter 0; iwait=dwait=1; iload=dload=0; ram_ren=ram_wen=0; ram_addr=0; ram_wdata=0.
- Reset mid-transaction returns to IDLE immediately with no further RAM strobes. A write already strobed is not undone.

## Timing
- Request sampled in IDLE at cycle 0.
- Write: ram_wen is high in cycle LAT+1; dwait is low in cycle LAT+2.
- Read: ram_ren is high in cycle LAT+1 and capture happens in LAT+2. The wait output is low, with load valid, in cycle LAT+3.
- Back-to-back: the cycle after DONE is IDLE and samples the next request. Spacing is therefore LAT+3 cycles per write and LAT+4 per read.
- All outputs are registered or decoded from state only. There is no combinational path from request inputs to wait outputs.

## Structure
- word_t comes from cpu_types_pkg. Add WORD_ADDR_W = 30 to the same package.
- The state enum stays local to the module.
- No sub-module; the counter and arbitration are inline.

## Test plan
- Data read, LAT=2, RAM[0x40>>2]=0xCAFEF00D, dREN=1 at daddr=0x40 -> ram_ren in cycle 3, dwait=0 with dload=0xCAFEF00D in cycle 5, dwait=1 in cycle 6.
- Data write, LAT=0, daddr=0x80, dstore=0x12345678 -> ram_wen=1 with ram_addr=0x20 in cycle 1, dwait=0 in cycle 2. A following read of 0x80 returns 0x12345678.
- Simultaneous iREN and dREN -> data served first, iwait held at 1 throughout. The instruction is granted in the IDLE after data DONE and completes LAT+3 cycles later.
- dREN=dWEN=1 -> write performed, ram_ren never asserted.
- dREN dropped during WAIT (LAT=4, drop in cycle 2) -> no RAM strobe, state IDLE in cycle 3, dwait stays 1.
- RST pulsed during WAIT of a write -> ram_wen never asserts, all outputs at reset values immediately, and a fresh request afterwards completes normally.
